// File: rtl/game_state_tracker.sv
// game_state_tracker: game FSM plus vaccine mask, BCD score, lives and
// corona-hit holdoff bookkeeping, driven by qualified collision pulses.
module game_state_tracker #(
   parameter logic [0:9]  INIT_VACCINES  = 10'b1111111111,
   parameter int unsigned START_LIVES    = 3,
   parameter int unsigned HOLDOFF_FRAMES = 30,
   // score loaded on reset and game start; 8'h00 for normal play, other
   // values let the saturation path be reached without 100 vaccines
   parameter logic [7:0]  SCORE_PRELOAD  = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       start_game,
   input  logic       SingleHitPulse,
   input  logic [3:0] collision_clamp_vaccine,
   input  logic [3:0] collision_clamp_corona,
   input  logic       upCounter,
   input  logic       downCounter,
   output logic [0:9] current_vaccines,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic [1:0] game_state,
   output logic       invulnerable
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      WIN  = 2'b10,
      LOSE = 2'b11
   } state_t;

   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [5:0] HOLD_INIT  = 6'(HOLDOFF_FRAMES);

   state_t     state_q, state_d;
   logic [0:9] vacc_q, vacc_d;
   logic [7:0] score_q, score_d;
   logic [1:0] lives_q, lives_d;
   logic [5:0] holdoff_q, holdoff_d;
   logic       inv_q, inv_d;

   logic [0:9] v_sel;
   logic [7:0] score_inc;
   logic       v_hit, c_hit;

   // one-hot decode of the vaccine clamp; 10..15 decode to no bit at all
   always_comb begin
      v_sel = '0;
      for (int i = 0; i < 10; i++) begin
         if (collision_clamp_vaccine == 4'(i)) v_sel[i] = 1'b1;
      end
   end

   // BCD increment with saturation at 99
   always_comb begin
      if (score_q == 8'h99)
         score_inc = score_q;
      else if (score_q[3:0] == 4'd9)
         score_inc = {score_q[7:4] + 4'd1, 4'd0};
      else
         score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
   end

   // hit qualification: vaccine must still be active, corona needs no holdoff
   always_comb begin
      v_hit = SingleHitPulse && upCounter && (|(v_sel & vacc_q));
      c_hit = SingleHitPulse && downCounter && (collision_clamp_corona < 4'd10)
              && !inv_q && (lives_q != 2'd0);
   end

   // next-state: FSM transitions, hit application and holdoff countdown
   always_comb begin
      state_d   = state_q;
      vacc_d    = vacc_q;
      score_d   = score_q;
      lives_d   = lives_q;
      holdoff_d = holdoff_q;
      // holdoff keeps counting in every state; a corona load below overrides
      if (startOfFrame && (holdoff_q != 6'd0)) holdoff_d = holdoff_q - 6'd1;
      case (state_q)
         PLAY: begin
            // end-of-game decisions look at the already-updated registers
            if (lives_q == 2'd0)
               state_d = LOSE;
            else if (vacc_q == '0)
               state_d = WIN;
            if (v_hit) begin
               vacc_d  = vacc_q & ~v_sel;
               score_d = score_inc;
            end
            if (c_hit) begin
               lives_d   = lives_q - 2'd1;
               holdoff_d = HOLD_INIT;
            end
         end
         default: begin
            if (start_game) begin
               state_d   = PLAY;
               vacc_d    = INIT_VACCINES;
               score_d   = SCORE_PRELOAD;
               lives_d   = LIVES_INIT;
               holdoff_d = 6'd0;
            end
         end
      endcase
      inv_d = (holdoff_d != 6'd0);
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // game datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vacc_q    <= INIT_VACCINES;
         score_q   <= SCORE_PRELOAD;
         lives_q   <= LIVES_INIT;
         holdoff_q <= 6'd0;
         inv_q     <= 1'b0;
      end else begin
         vacc_q    <= vacc_d;
         score_q   <= score_d;
         lives_q   <= lives_d;
         holdoff_q <= holdoff_d;
         inv_q     <= inv_d;
      end
   end

   assign current_vaccines = vacc_q;
   assign score            = score_q;
   assign lives            = lives_q;
   assign game_state       = state_q;
   assign invulnerable     = inv_q;

endmodule

// File: tb/tb_game_state_tracker.sv
// Bench for game_state_tracker: directed table, hand-written corner
// sequences, then random stimulus against an integer-level game model.
module tb_game_state_tracker;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sof = 1'b0, start = 1'b0, pulse = 1'b0, up = 1'b0, dn = 1'b0;
   logic [3:0] cv = 4'hf, cc = 4'hf;
   logic [0:9] mask, mask2;
   logic [7:0] score, score2;
   logic [1:0] lives, lives2, gs, gs2;
   logic       inv, inv2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   game_state_tracker dut (
      .clk(clk), .reset(reset), .startOfFrame(sof), .start_game(start),
      .SingleHitPulse(pulse), .collision_clamp_vaccine(cv),
      .collision_clamp_corona(cc), .upCounter(up), .downCounter(dn),
      .current_vaccines(mask), .score(score), .lives(lives),
      .game_state(gs), .invulnerable(inv));

   game_state_tracker #(.SCORE_PRELOAD(8'h97)) dut2 (
      .clk(clk), .reset(reset), .startOfFrame(sof), .start_game(start),
      .SingleHitPulse(pulse), .collision_clamp_vaccine(cv),
      .collision_clamp_corona(cc), .upCounter(up), .downCounter(dn),
      .current_vaccines(mask2), .score(score2), .lives(lives2),
      .game_state(gs2), .invulnerable(inv2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] e_gs, input logic [0:9] e_m,
                            input logic [7:0] e_sc, input logic [1:0] e_lv, input logic e_inv);
      chk({tag, ".state"}, 32'(gs), 32'(e_gs));
      chk({tag, ".mask"}, 32'(mask), 32'(e_m));
      chk({tag, ".score"}, 32'(score), 32'(e_sc));
      chk({tag, ".lives"}, 32'(lives), 32'(e_lv));
      chk({tag, ".inv"}, 32'(inv), 32'(e_inv));
   endtask

   // one clock with the currently driven inputs, then back to quiet inputs
   task automatic tick();
      @(posedge clk);
      #1;
      start = 0; pulse = 0; up = 0; dn = 0; sof = 0; cv = 4'hf; cc = 4'hf;
   endtask

   task automatic sof_n(input int n);
      for (int k = 0; k < n; k++) begin
         sof = 1; tick(); tick();
      end
   endtask

   task automatic vhit(input int idx);
      pulse = 1; up = 1; cv = 4'(idx); tick();
   endtask

   task automatic chit(input int idx, input logic with_sof);
      pulse = 1; dn = 1; cc = 4'(idx); sof = with_sof; tick();
   endtask

   // ---------------- reference model (integer game rules) ----------------
   int m_st, m_cnt, m_lives, m_hold;
   bit m_mask[10];

   function automatic logic [0:9] m_maskv();
      logic [0:9] v;
      for (int i = 0; i < 10; i++) v[i] = m_mask[i];
      return v;
   endfunction

   function automatic logic [7:0] m_bcd();
      return 8'(((m_cnt / 10) << 4) | (m_cnt % 10));
   endfunction

   task automatic m_reset();
      m_st = 0; m_cnt = 0; m_lives = 3; m_hold = 0;
      for (int i = 0; i < 10; i++) m_mask[i] = 1;
   endtask

   task automatic m_step();
      int nh, nst, remaining;
      nh = (sof && m_hold > 0) ? m_hold - 1 : m_hold;
      if (m_st != 1) begin
         if (start) begin
            m_reset();
            m_st = 1;
         end else begin
            m_hold = nh;
         end
         return;
      end
      remaining = 0;
      for (int i = 0; i < 10; i++) remaining += m_mask[i];
      nst = (m_lives == 0) ? 3 : (remaining == 0) ? 2 : 1;
      if (pulse) begin
         if (up && cv < 10 && m_mask[cv]) begin
            m_mask[cv] = 0;
            if (m_cnt < 99) m_cnt++;
         end
         if (dn && cc < 10 && m_hold == 0 && m_lives > 0) begin
            m_lives--;
            nh = 30;
         end
      end
      m_hold = nh;
      m_st = nst;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic       st, pu, up;
      logic [3:0] cv;
      logic       dn;
      logic [3:0] cc;
      logic       sf;
      logic [1:0] e_gs;
      logic [0:9] e_m;
      logic [7:0] e_sc;
      logic [1:0] e_lv;
      logic       e_inv;
   } vec_t;

   vec_t tv[11];

   initial begin
      tv[0]  = '{1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 4'd15, 1'b0, 2'b00, 10'b1111111111, 8'h00, 2'd3, 1'b0};
      tv[1]  = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 4'd15, 1'b0, 2'b01, 10'b1111111111, 8'h00, 2'd3, 1'b0};
      tv[2]  = '{1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 4'd15, 1'b0, 2'b01, 10'b1110111111, 8'h01, 2'd3, 1'b0};
      tv[3]  = '{1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 4'd15, 1'b0, 2'b01, 10'b1110111111, 8'h01, 2'd3, 1'b0};
      tv[4]  = '{1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 4'd15, 1'b0, 2'b01, 10'b1110111111, 8'h01, 2'd3, 1'b0};
      tv[5]  = '{1'b0, 1'b1, 1'b0, 4'd15, 1'b1, 4'd5,  1'b0, 2'b01, 10'b1110111111, 8'h01, 2'd2, 1'b1};
      tv[6]  = '{1'b0, 1'b1, 1'b0, 4'd15, 1'b1, 4'd5,  1'b0, 2'b01, 10'b1110111111, 8'h01, 2'd2, 1'b1};
      tv[7]  = '{1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 4'd15, 1'b0, 2'b01, 10'b1110111111, 8'h01, 2'd2, 1'b1};
      tv[8]  = '{1'b0, 1'b1, 1'b1, 4'd0,  1'b1, 4'd15, 1'b0, 2'b01, 10'b0110111111, 8'h02, 2'd2, 1'b1};
      tv[9]  = '{1'b0, 1'b1, 1'b0, 4'd1,  1'b0, 4'd1,  1'b0, 2'b01, 10'b0110111111, 8'h02, 2'd2, 1'b1};
      tv[10] = '{1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 4'd15, 1'b1, 2'b01, 10'b0110111111, 8'h02, 2'd2, 1'b1};
   end

   initial begin
      #2 reset = 1;
      #2;
      check_all("reset", 2'b00, 10'b1111111111, 8'h00, 2'd3, 1'b0);
      chk("reset.score_preload", 32'(score2), 32'h97);
      @(negedge clk);
      reset = 0;
      #1;

      for (int r = 0; r < 11; r++) begin
         start = tv[r].st; pulse = tv[r].pu; up = tv[r].up; cv = tv[r].cv;
         dn = tv[r].dn; cc = tv[r].cc; sof = tv[r].sf;
         tick();
         check_all($sformatf("row%0d", r), tv[r].e_gs, tv[r].e_m, tv[r].e_sc, tv[r].e_lv, tv[r].e_inv);
      end
      chk("sat.score_reaches_99", 32'(score2), 32'h99);

      // holdoff: one frame already consumed, 28 more keep it alive, 30th clears
      sof_n(28);
      chk("holdoff.still_inv", 32'(inv), 32'h1);
      sof_n(1);
      check_all("holdoff.expired", 2'b01, 10'b0110111111, 8'h02, 2'd2, 1'b0);
      // corona hit with a coincident frame pulse reloads the full holdoff
      chit(9, 1'b1);
      check_all("holdoff.reload", 2'b01, 10'b0110111111, 8'h02, 2'd1, 1'b1);
      sof_n(29);
      chk("holdoff.load_beats_dec", 32'(inv), 32'h1);
      sof_n(1);
      chk("holdoff.load_expired", 32'(inv), 32'h0);

      // clear down to the last vaccine; score crosses 09 -> 10 on the last hit
      for (int i = 1; i < 9; i++) if (i != 3) vhit(i);
      check_all("win.pre", 2'b01, 10'b0000000001, 8'h09, 2'd1, 1'b0);
      chk("sat.score_holds_99", 32'(score2), 32'h99);
      vhit(9);
      check_all("win.last_hit", 2'b01, 10'b0000000000, 8'h10, 2'd1, 1'b0);
      tick();
      chk("win.state", 32'(gs), 32'h2);
      pulse = 1; dn = 1; cc = 4'd3; up = 1; cv = 4'd2;
      tick();
      check_all("win.hold", 2'b10, 10'b0000000000, 8'h10, 2'd1, 1'b0);
      start = 1;
      tick();
      check_all("win.restart", 2'b01, 10'b1111111111, 8'h00, 2'd3, 1'b0);

      // lose priority: last vaccine and final life in the same pulse
      chit(0, 1'b0); sof_n(30);
      chit(0, 1'b0); sof_n(30);
      for (int i = 0; i < 9; i++) vhit(i);
      check_all("lose.pre", 2'b01, 10'b0000000001, 8'h09, 2'd1, 1'b0);
      pulse = 1; up = 1; cv = 4'd9; dn = 1; cc = 4'd4;
      tick();
      check_all("lose.hit", 2'b01, 10'b0000000000, 8'h10, 2'd0, 1'b1);
      tick();
      chk("lose.state", 32'(gs), 32'h3);
      sof_n(30);
      check_all("lose.holdoff_runs", 2'b11, 10'b0000000000, 8'h10, 2'd0, 1'b0);

      // reset in the middle of a game with a hit pending
      start = 1; tick();
      vhit(2);
      chk("rst.pre_score", 32'(score), 32'h01);
      pulse = 1; up = 1; cv = 4'd5; dn = 1; cc = 4'd5;
      #2 reset = 1;
      #1;
      check_all("rst.async", 2'b00, 10'b1111111111, 8'h00, 2'd3, 1'b0);
      @(posedge clk);
      #1;
      start = 0; pulse = 0; up = 0; dn = 0; cv = 4'hf; cc = 4'hf;
      #1 reset = 0;
      tick();
      check_all("rst.released", 2'b00, 10'b1111111111, 8'h00, 2'd3, 1'b0);
      pulse = 1; up = 1; cv = 4'd4; dn = 1; cc = 4'd4;
      tick();
      check_all("rst.idle_ignores", 2'b00, 10'b1111111111, 8'h00, 2'd3, 1'b0);

      // randomized play against the integer model
      reset = 1; #2 reset = 0;
      m_reset();
      for (int n = 0; n < 4000 && failures < 20; n++) begin
         start = ($urandom_range(0, 39) == 0);
         pulse = ($urandom_range(0, 2) == 0);
         sof   = ($urandom_range(0, 4) == 0);
         up    = 1'($urandom);
         dn    = ($urandom_range(0, 3) == 0);
         cv    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         cc    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         @(posedge clk);
         m_step();
         #1;
         check_all($sformatf("rand%0d", n), 2'(m_st), m_maskv(), m_bcd(), 2'(m_lives), (m_hold != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
